// File: rtl/ma_pkg.sv
// Shared types and constants for the ma_shift_reg multiplier datapath register.
// Holds the shift command encoding (ma_op_t) and the controller state enum.
package ma_pkg;

  localparam int unsigned OP_W    = 3;
  localparam int unsigned STATE_W = 2;

  // Shift command, sampled together with start
  typedef enum logic [OP_W-1:0] {
    OP_HOLD = 3'd0,
    OP_SHL  = 3'd1,
    OP_SHR  = 3'd2,
    OP_ASHR = 3'd3,
    OP_ROL  = 3'd4,
    OP_ROR  = 3'd5,
    OP_SCLR = 3'd6,
    OP_RSVD = 3'd7
  } ma_op_t;

  // Command controller states
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } ma_state_t;

  // SCLR completes in a single shift cycle regardless of the requested count
  function automatic logic is_single_cycle(input ma_op_t op);
    return op == OP_SCLR;
  endfunction

endpackage

// File: rtl/ma_shift_unit.sv
// Combinational one-step shift function for ma_shift_reg.
// Given the current register value, a command and the serial input, returns
// the next register value, the bit shifted out, and whether sout updates.
// Config macro MA_ROTATE_EN: when undefined, ROL/ROR decode as HOLD and the
// rotate paths are not built.
// Ports:
//   qa          current register contents
//   op          shift command
//   sin         serial input bit for SHL/SHR
//   nxt_qa_c    next register contents
//   nxt_sout_c  bit shifted out by this step
//   sout_upd_c  high when this command produces a new sout
module ma_shift_unit
  import ma_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] qa,
  input  ma_op_t           op,
  input  logic             sin,
  output logic [WIDTH-1:0] nxt_qa_c,
  output logic             nxt_sout_c,
  output logic             sout_upd_c
);

  // Per-command next value; anything not listed holds
  always_comb begin
    nxt_qa_c   = qa;
    nxt_sout_c = 1'b0;
    sout_upd_c = 1'b0;
    case (op)
      OP_SHL: begin
        nxt_qa_c   = {qa[WIDTH-2:0], sin};
        nxt_sout_c = qa[WIDTH-1];
        sout_upd_c = 1'b1;
      end
      OP_SHR: begin
        nxt_qa_c   = {sin, qa[WIDTH-1:1]};
        nxt_sout_c = qa[0];
        sout_upd_c = 1'b1;
      end
      OP_ASHR: begin
        nxt_qa_c   = {qa[WIDTH-1], qa[WIDTH-1:1]};
        nxt_sout_c = qa[0];
        sout_upd_c = 1'b1;
      end
`ifdef MA_ROTATE_EN
      OP_ROL: begin
        nxt_qa_c   = {qa[WIDTH-2:0], qa[WIDTH-1]};
        nxt_sout_c = qa[WIDTH-1];
        sout_upd_c = 1'b1;
      end
      OP_ROR: begin
        nxt_qa_c   = {qa[0], qa[WIDTH-1:1]};
        nxt_sout_c = qa[0];
        sout_upd_c = 1'b1;
      end
`endif
      // Clearing does not disturb the last shifted-out bit
      OP_SCLR: begin
        nxt_qa_c = '0;
      end
      default: begin
        nxt_qa_c = qa;
      end
    endcase
  end

endmodule

// File: rtl/ma_shift_reg.sv
// Parametrised shift/load register for the multiplier datapath.
// Parallel load and clear plus logical, arithmetic and rotate shifts, with a
// start/busy/done handshake that runs one command for up to WIDTH shifts.
// Config macro MA_ROTATE_EN (see ma_shift_unit): enables ROL/ROR.
// Ports:
//   clk    rising-edge clock
//   clr_n  asynchronous active-low reset
//   ld     parallel load strobe (wins over start)
//   da     parallel load data
//   op     shift command, sampled with start
//   start  begin a shift command
//   cnt    number of shifts, sampled with start (clamped to WIDTH)
//   sin    serial input for SHL/SHR, sampled every shift cycle
//   qa     register contents
//   sout   bit most recently shifted out
//   busy   command in progress
//   done   one-cycle completion pulse
module ma_shift_reg
  import ma_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] da,
  input  logic [OP_W-1:0]  op,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  input  logic             sin,
  output logic [WIDTH-1:0] qa,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  ma_state_t        state;
  ma_op_t           op_q;
  logic [CNT_W-1:0] rem_q;

  logic [WIDTH-1:0] nxt_qa_c;
  logic             nxt_sout_c;
  logic             sout_upd_c;
  ma_op_t           op_in_c;
  logic [CNT_W-1:0] cnt_clamp_c;

  assign op_in_c     = ma_op_t'(op);
  assign cnt_clamp_c = (cnt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cnt;

  // Next value for one step of the latched command
  ma_shift_unit #(
    .WIDTH (WIDTH)
  ) u_shift (
    .qa         (qa),
    .op         (op_q),
    .sin        (sin),
    .nxt_qa_c   (nxt_qa_c),
    .nxt_sout_c (nxt_sout_c),
    .sout_upd_c (sout_upd_c)
  );

  // Command controller and datapath registers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= ST_IDLE;
      op_q  <= OP_HOLD;
      rem_q <= '0;
      qa    <= '0;
      sout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // FIN accepts new work exactly like IDLE so commands can chain
        ST_IDLE, ST_FIN: begin
          done  <= (state == ST_FIN);
          state <= ST_IDLE;
          if (ld) begin
            qa <= da;
          end else if (start) begin
            if (cnt == '0) begin
              state <= ST_FIN;
            end else begin
              op_q  <= op_in_c;
              rem_q <= is_single_cycle(op_in_c) ? CNT_W'(1) : cnt_clamp_c;
              state <= ST_RUN;
              busy  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          qa    <= nxt_qa_c;
          rem_q <= rem_q - CNT_W'(1);
          if (sout_upd_c) begin
            sout <= nxt_sout_c;
          end
          if (rem_q == CNT_W'(1)) begin
            state <= ST_FIN;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ma_shift_reg.sv
// Self-checking bench for ma_shift_reg: directed test-plan steps followed by
// randomized commands, compared against an arithmetic reference model.
module tb_ma_shift_reg;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = $clog2(W + 1);
  localparam int          M  = 1 << W;
  localparam int          H  = 1 << (W - 1);

  logic          clk = 1'b0;
  logic          clr_n;
  logic          ld;
  logic [W-1:0]  da;
  logic [2:0]    op;
  logic          start;
  logic [CW-1:0] cnt;
  logic          sin;
  logic [W-1:0]  qa;
  logic          sout;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;
  int m_q;
  int m_sout;

  ma_shift_reg #(.WIDTH(W)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .ld    (ld),
    .da    (da),
    .op    (op),
    .start (start),
    .cnt   (cnt),
    .sin   (sin),
    .qa    (qa),
    .sout  (sout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int exp_busy, input int exp_done);
    check({tag, ".qa"},   32'(qa),   32'(m_q));
    check({tag, ".sout"}, 32'(sout), 32'(m_sout));
    check({tag, ".busy"}, 32'(busy), 32'(exp_busy));
    check({tag, ".done"}, 32'(done), 32'(exp_done));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One shift step of the register, written as plain integer arithmetic
  function automatic void model_step(input int o, input int s);
    int v;
    v = m_q;
    case (o)
      1: begin m_q = (v * 2 + s) % M;           m_sout = v / H; end
      2: begin m_q = v / 2 + s * H;             m_sout = v % 2; end
      3: begin m_q = v / 2 + ((v >= H) ? H : 0); m_sout = v % 2; end
`ifdef MA_ROTATE_EN
      4: begin m_q = (v * 2) % M + v / H;       m_sout = v / H; end
      5: begin m_q = v / 2 + (v % 2) * H;       m_sout = v % 2; end
`endif
      6: m_q = 0;
      default: m_q = v;
    endcase
  endfunction

  task automatic load(input int d);
    ld = 1'b1;
    da = W'(d);
    tick;
    ld = 1'b0;
    m_q = d;
    check_all("load", 0, 0);
  endtask

  // Issue one command and follow it through RUN, FIN and the done pulse.
  // sin_fix < 0 randomizes sin; noise drives ignored ld/start traffic while busy.
  task automatic cmd(input string tag, input int o, input int c, input int sin_fix, input bit noise);
    int n;
    int s;
    op    = 3'(o);
    cnt   = CW'(c);
    start = 1'b1;
    ld    = 1'b0;
    tick;
    start = 1'b0;
    n = (c == 0) ? 0 : (o == 6) ? 1 : ((c > W) ? W : c);
    for (int i = 0; i < n; i++) begin
      check_all({tag, ".run"}, 1, 0);
      if (noise) begin
        ld    = 1'($urandom);
        start = 1'($urandom);
        da    = W'($urandom);
        op    = 3'($urandom);
        cnt   = CW'($urandom);
      end
      s   = (sin_fix < 0) ? int'($urandom % 2) : sin_fix;
      sin = 1'(s);
      tick;
      model_step(o, s);
    end
    ld    = 1'b0;
    start = 1'b0;
    check_all({tag, ".fin"}, 0, 0);
    if (noise && ($urandom % 4 == 0)) begin
      ld = 1'b1;
      da = W'($urandom);
      tick;
      m_q = int'(da);
      ld  = 1'b0;
    end else begin
      tick;
    end
    check_all({tag, ".done"}, 0, 1);
    tick;
    check_all({tag, ".idle"}, 0, 0);
  endtask

  initial begin
    clr_n = 1'b0;
    ld    = 1'b0;
    start = 1'b0;
    da    = '0;
    op    = '0;
    cnt   = '0;
    sin   = 1'b0;
    m_q    = 0;
    m_sout = 0;
    #3;
    check_all("por", 0, 0);
    @(negedge clk);
    clr_n = 1'b1;
    tick;

    // Reset mid-cycle with a loaded value
    load(4'b1011);
    #2;
    clr_n = 1'b0;
    #1;
    m_q = 0;
    m_sout = 0;
    check_all("reset", 0, 0);
    @(negedge clk);
    clr_n = 1'b1;
    tick;

    // Load, then ld and start together: load only
    load(4'b1011);
    ld = 1'b1; start = 1'b1; da = 4'b0110; op = 3'd1; cnt = CW'(2);
    tick;
    ld = 1'b0; start = 1'b0;
    m_q = 4'b0110;
    check_all("ld_start", 0, 0);
    tick;
    check_all("ld_start2", 0, 0);

    // SHL of 1011 by 2 with sin=0 -> 0110, 1100; sout 1 then 0
    load(4'b1011);
    cmd("shl", 1, 2, 0, 1'b0);
    check("shl.final", 32'(qa), 32'(4'b1100));

    // ASHR of 1000 by 3 -> 1111, sout 0
    load(4'b1000);
    cmd("ashr", 3, 3, -1, 1'b0);
    check("ashr.final", 32'(qa), 32'(4'b1111));

    // Count above WIDTH clamps to WIDTH shifts
    load(int'($urandom % M));
    cmd("clamp", 1, 7, -1, 1'b0);

    // ROR by 1 (HOLD when rotate is disabled)
    load(4'b0001);
    cmd("ror", 5, 1, -1, 1'b0);

    // SCLR takes one cycle whatever the count
    load(4'b1101);
    cmd("sclr", 6, 4, -1, 1'b0);

    // Zero count: done next cycle, busy never asserts
    cmd("cnt0", 1, 0, -1, 1'b0);

    // Abort SHL cnt=4 after two shifts
    load(4'b0111);
    op = 3'd1; cnt = CW'(4); start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sin = 1'b1;
      tick;
      model_step(1, 1);
      check_all("abort.shift", (i == 0) ? 1 : 1, 0);
    end
    #2;
    clr_n = 1'b0;
    #1;
    m_q = 0;
    m_sout = 0;
    check_all("abort.rst", 0, 0);
    @(negedge clk);
    clr_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      check_all("abort.after", 0, 0);
    end

    // Randomized commands with ignored traffic while busy
    for (int t = 0; t < 60; t++) begin
      if ($urandom % 3 == 0) load(int'($urandom % M));
      cmd("rnd", int'($urandom % 8), int'($urandom % 8), -1, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ma_shift_reg.md
# ma_shift_reg

Parametrised shift and load register for the multiplier datapath. It keeps the parallel load and clear of the existing 4-bit operand register and adds logical, arithmetic and rotate shifts. A start/busy/done handshake lets one command shift the register up to WIDTH positions. The controller uses it for multiplicand and accumulator shifting.

## Interface
- WIDTH, 4: register width in bits, ≥ 2.
- CNT_W, $clog2(WIDTH+1): width of the shift count port (derived; do not override).

- clk  in  1  rising-edge clock.
- clr_n  in  1  asynchronous, active-low reset.
- ld  in  1  parallel load strobe.
- da  in  WIDTH  parallel load data.
- op  in  3  shift command, sampled with start.
- start  in  1  begin a shift command.
- cnt  in  CNT_W  number of shifts, sampled with start.
- sin  in  1  serial input for SHL/SHR, sampled on every shift cycle.
- qa  out  WIDTH  register contents.
- sout  out  1  bit most recently shifted out (registered).
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- op encoding:
  - 0 HOLD.
  - 1 SHL: qa <= {qa[W-2:0], sin}, sout <= qa[W-1].
  - 2 SHR: qa <= {sin, qa[W-1:1]}, sout <= qa[0].
  - 3 ASHR: MSB replicated, sout <= qa[0].
  - 4 ROL, 5 ROR: sout <= bit that wraps.
  - 6 SCLR: qa <= 0 in one shift cycle; sout unchanged.
  - 7 is treated as HOLD.
- FSM states:
  - IDLE
    - ld=1: qa <= da. ld wins over start in the same cycle; start is dropped.
    - else start=1 and cnt=0: go to FIN, qa untouched.
    - else start=1: latch op, latch rem = min(cnt, WIDTH), go to RUN. A cnt above WIDTH is clamped to WIDTH.
  - RUN
    - Each cycle: apply latched op and decrement rem.
    - If rem=1 before the decrement, go to FIN.
    - SCLR always takes exactly one RUN cycle, whatever cnt is.
  - FIN: done=1 for one cycle, then IDLE. ld/start are accepted in FIN, so back-to-back commands are possible.
- busy = (state == RUN). ld, start, op and cnt are ignored while busy.
- HOLD with cnt=N still spends N RUN cycles with qa unchanged.
- Reset values:
  - qa = 0, sout = 0, busy = 0, done = 0, state = IDLE.
  - Latched op and rem are cleared.
- Reset mid-command aborts immediately. No done pulse follows the abort.

## Timing
- start is sampled at edge k.
- Shifts occur at edges k+1 … k+N.
- busy is high in the cycles between edge k and edge k+N.
- done is high between edges k+N+1 and k+N+2.
- With cnt=0, done is high between edges k+1 and k+2 and busy never asserts.
- ld latency: qa updates at the sampling edge.
- sout changes only on shift edges. It is stable at all other times.

## Configuration
- MA_ROTATE_EN
  - Defined: ROL/ROR behave as specified above.
  - Undefined: op 4 and 5 decode as HOLD, with identical handshake timing.
  - The rotate paths are removed from the shift unit either way when undefined.

## Structure
- Package ma_pkg holds:
  - the op enum (ma_op_t) with encodings 0–7;
  - the FSM state enum (IDLE/RUN/FIN);
  - the shared op constants.
- Sub-module ma_shift_unit: a combinational next-value/next-sout function of (qa, op, sin). It holds the MA_ROTATE_EN gating. The top level holds the FSM, the counter and the registers.

## Test plan
1. **Reset:** clr_n low mid-cycle with qa=4'b1011 → immediately qa=0, sout=0, busy=0, done=0.
2. **Load:** ld=1, da=4'b1011 → qa=4'b1011 after one edge. ld and start together → load only, no busy.
3. **SHL:** qa=4'b1011, op=SHL, cnt=2, sin=0.
   - qa goes 4'b0110 then 4'b1100; sout goes 1 then 0.
   - busy is high for 2 cycles, then done pulses once.
4. **ASHR:** qa=4'b1000, op=ASHR, cnt=3 → qa goes 4'b1100, 4'b1110, 4'b1111; sout ends at 0. **cnt clamp:** cnt=7 with WIDTH=4 gives exactly 4 shifts.
5. **Rotate:** qa=4'b0001, op=ROR, cnt=1.
   - With MA_ROTATE_EN: qa=4'b1000, sout=1.
   - Without MA_ROTATE_EN: qa stays 4'b0001, and busy and done are still identical.
6. **cnt=0 and abort:**
   - start with cnt=0 → done next cycle, busy stays low.
   - SHL cnt=4 with clr_n pulsed after 2 shifts → qa=0, busy drops, and no done pulse follows.
